// File: rtl/mux_tree_n_to_1.sv
// Pipelined N-to-1 radix-R selector tree with fixed or round-robin lane choice; latency NUM_STAGES cycles.
// Backpressure: the whole pipe (and rr_ptr) freezes when out_valid & ~out_ready; in_ready mirrors the advance enable.
module mux_tree_n_to_1 #(
    parameter int DATA_WIDTH      = 96,
    parameter int NUM_INPUT_PORTS = 5,
    parameter int RADIX           = 4,
    parameter int SEL_WIDTH       = 3
) (
    input  logic                                  clk,
    input  logic                                  rst,
    input  logic [SEL_WIDTH-1:0]                  sel,
    input  logic                                  rr_mode,
    input  logic [NUM_INPUT_PORTS-1:0]            in_valid,
    input  logic [NUM_INPUT_PORTS*DATA_WIDTH-1:0] in,
    output logic                                  in_ready,
    input  logic                                  out_ready,
    output logic [DATA_WIDTH-1:0]                 out,
    output logic                                  out_valid,
    output logic [SEL_WIDTH-1:0]                  out_sel
);

    localparam int N = NUM_INPUT_PORTS;
    // Padded lane count: every j*RADIX+d index of any stage stays in range.
    localparam int P = NUM_INPUT_PORTS * RADIX;

    function automatic int calc_stages();
        int c;
        int s;
        c = NUM_INPUT_PORTS;
        s = 0;
        while (c > 1) begin
            c = (c + RADIX - 1) / RADIX;
            s++;
        end
        return (s < 1) ? 1 : s;
    endfunction

    localparam int NUM_STAGES = calc_stages();

    function automatic int grp_cnt(input int lvl);
        int c;
        c = NUM_INPUT_PORTS;
        for (int i = 0; i < lvl; i++) c = (c + RADIX - 1) / RADIX;
        return c;
    endfunction

    function automatic int rpow(input int lvl);
        int p;
        p = 1;
        for (int i = 0; i < lvl; i++) p = p * RADIX;
        return p;
    endfunction

    logic [DATA_WIDTH-1:0] lane_pad [P];
    logic [DATA_WIDTH-1:0] stg_dat  [NUM_STAGES][P];
    logic [DATA_WIDTH-1:0] nxt_dat  [NUM_STAGES][P];
    logic [SEL_WIDTH-1:0]  stg_idx  [NUM_STAGES];
    logic [SEL_WIDTH-1:0]  nxt_idx  [NUM_STAGES];
    logic                  stg_vld  [NUM_STAGES];
    logic                  nxt_vld  [NUM_STAGES];

    logic [SEL_WIDTH-1:0] rr_ptr;
    logic [SEL_WIDTH-1:0] rr_idx;
    logic [SEL_WIDTH-1:0] fix_idx;
    logic [SEL_WIDTH-1:0] idx;
    logic                 rr_vld;
    logic                 fix_vld;
    logic                 item_vld;
    logic                 en;
    int                   rr_best;

    assign en       = out_ready | ~out_valid;
    assign in_ready = en;

    always_comb begin
        fix_idx = (int'(sel) < N) ? sel : '0;
        fix_vld = 1'b0;
        for (int i = 0; i < N; i++)
            if (int'(fix_idx) == i) fix_vld = in_valid[i];
    end

    // Closest valid lane after rr_ptr, measured as a wrap-around distance.
    always_comb begin
        rr_idx  = rr_ptr;
        rr_vld  = 1'b0;
        rr_best = N;
        for (int i = 0; i < N; i++) begin
            if (in_valid[i] && ((i + 2 * N - int'(rr_ptr) - 1) % N) < rr_best) begin
                rr_best = (i + 2 * N - int'(rr_ptr) - 1) % N;
                rr_idx  = SEL_WIDTH'(i);
                rr_vld  = 1'b1;
            end
        end
    end

    assign idx      = rr_mode ? rr_idx : fix_idx;
    assign item_vld = rr_mode ? rr_vld : fix_vld;

    always_comb begin
        for (int i = 0; i < P; i++) lane_pad[i] = '0;
        for (int i = 0; i < N; i++) lane_pad[i] = in[i*DATA_WIDTH +: DATA_WIDTH];
    end

    // Each stage picks within its group by one base-RADIX digit of the item's own idx.
    always_comb begin
        for (int k = 0; k < NUM_STAGES; k++)
            for (int j = 0; j < P; j++) nxt_dat[k][j] = '0;
        for (int j = 0; j < N; j++) begin
            if (j < grp_cnt(1)) begin
                nxt_dat[0][j] = lane_pad[j*RADIX];
                for (int d = 1; d < RADIX; d++)
                    if (d == int'(idx) % RADIX && j * RADIX + d < N)
                        nxt_dat[0][j] = lane_pad[j*RADIX+d];
            end
        end
        for (int k = 1; k < NUM_STAGES; k++) begin
            for (int j = 0; j < N; j++) begin
                if (j < grp_cnt(k + 1)) begin
                    nxt_dat[k][j] = stg_dat[k-1][j*RADIX];
                    for (int d = 1; d < RADIX; d++)
                        if (d == (int'(stg_idx[k-1]) / rpow(k)) % RADIX && j * RADIX + d < grp_cnt(k))
                            nxt_dat[k][j] = stg_dat[k-1][j*RADIX+d];
                end
            end
        end
    end

    always_comb begin
        nxt_idx[0] = idx;
        nxt_vld[0] = item_vld;
        for (int k = 1; k < NUM_STAGES; k++) begin
            nxt_idx[k] = stg_idx[k-1];
            nxt_vld[k] = stg_vld[k-1];
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            stg_dat <= '{default: '{default: '0}};
            stg_idx <= '{default: '0};
            stg_vld <= '{default: 1'b0};
            rr_ptr  <= SEL_WIDTH'(N - 1);
        end else if (en) begin
            stg_dat <= nxt_dat;
            stg_idx <= nxt_idx;
            stg_vld <= nxt_vld;
            if (rr_mode && item_vld) rr_ptr <= idx;
        end
    end

    assign out       = stg_dat[NUM_STAGES-1][0];
    assign out_valid = stg_vld[NUM_STAGES-1];
    assign out_sel   = stg_idx[NUM_STAGES-1];

endmodule

// File: tb/tb_mux_tree_n_to_1.sv
// Bench for mux_tree_n_to_1: vector table, round-robin/backpressure/reset sequences, random run vs model, parameter sweep.
module tb_mux_tree_n_to_1;

    localparam int DW = 96;
    localparam int N  = 5;
    localparam int SW = 3;
    localparam int L  = 2;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic            rst;
    logic [SW-1:0]   sel;
    logic            rr_mode;
    logic [N-1:0]    in_valid;
    logic [DW-1:0]   lanes [N];
    logic [N*DW-1:0] in_bus;
    logic            in_ready;
    logic            out_ready;
    logic [DW-1:0]   out_dat;
    logic            out_valid;
    logic [SW-1:0]   out_sel;

    always_comb begin
        in_bus = '0;
        for (int i = 0; i < N; i++) in_bus[i*DW +: DW] = lanes[i];
    end

    mux_tree_n_to_1 #(.DATA_WIDTH(DW), .NUM_INPUT_PORTS(N), .RADIX(4), .SEL_WIDTH(SW)) dut (
        .clk(clk), .rst(rst), .sel(sel), .rr_mode(rr_mode), .in_valid(in_valid), .in(in_bus),
        .in_ready(in_ready), .out_ready(out_ready), .out(out_dat), .out_valid(out_valid), .out_sel(out_sel));

    // Parameter sweep instances (16-bit lanes, always ready, fixed mode)
    logic [3:0]     sel16;  logic [15:0] iv16; logic [255:0] in16; logic [15:0] o16; logic ov16, ir16; logic [3:0] os16;
    logic [4:0]     sel17;  logic [16:0] iv17; logic [271:0] in17; logic [15:0] o17; logic ov17, ir17; logic [4:0] os17;
    logic [0:0]     sel2;   logic [1:0]  iv2;  logic [31:0]  in2;  logic [15:0] o2;  logic ov2, ir2;   logic [0:0] os2;

    always_comb begin
        for (int i = 0; i < 16; i++) in16[i*16 +: 16] = 16'(256 + i);
        for (int i = 0; i < 17; i++) in17[i*16 +: 16] = 16'(512 + i);
        for (int i = 0; i < 2; i++)  in2[i*16 +: 16]  = 16'(768 + i);
    end

    mux_tree_n_to_1 #(.DATA_WIDTH(16), .NUM_INPUT_PORTS(16), .RADIX(4), .SEL_WIDTH(4)) dut16 (
        .clk(clk), .rst(rst), .sel(sel16), .rr_mode(1'b0), .in_valid(iv16), .in(in16),
        .in_ready(ir16), .out_ready(1'b1), .out(o16), .out_valid(ov16), .out_sel(os16));
    mux_tree_n_to_1 #(.DATA_WIDTH(16), .NUM_INPUT_PORTS(17), .RADIX(4), .SEL_WIDTH(5)) dut17 (
        .clk(clk), .rst(rst), .sel(sel17), .rr_mode(1'b0), .in_valid(iv17), .in(in17),
        .in_ready(ir17), .out_ready(1'b1), .out(o17), .out_valid(ov17), .out_sel(os17));
    mux_tree_n_to_1 #(.DATA_WIDTH(16), .NUM_INPUT_PORTS(2), .RADIX(4), .SEL_WIDTH(1)) dut2 (
        .clk(clk), .rst(rst), .sel(sel2), .rr_mode(1'b0), .in_valid(iv2), .in(in2),
        .in_ready(ir2), .out_ready(1'b1), .out(o2), .out_valid(ov2), .out_sel(os2));

    int errors = 0;
    int checks = 0;

    function automatic void chk(string name, logic [127:0] act, logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endfunction

    // Reference model: pipeline as a queue of L items, oldest at the output.
    typedef struct packed {
        logic [DW-1:0] dat;
        logic          vld;
        logic [SW-1:0] sel;
    } item_t;

    item_t mq[$];
    int    m_ptr;

    function automatic void model_reset();
        mq.delete();
        for (int i = 0; i < L; i++) mq.push_back('0);
        m_ptr = N - 1;
    endfunction

    function automatic item_t pick();
        item_t r;
        int    i;
        r = '0;
        if (!rr_mode) begin
            i = (int'(sel) < N) ? int'(sel) : 0;
            r.vld = in_valid[i];
        end else begin
            i = m_ptr;
            for (int o = 1; o <= N; o++)
                if (!r.vld && in_valid[(m_ptr + o) % N]) begin
                    r.vld = 1'b1;
                    i = (m_ptr + o) % N;
                end
        end
        r.sel = SW'(i);
        r.dat = lanes[i];
        return r;
    endfunction

    // Called at posedge+1 with inputs set; returns at the following posedge+1.
    task automatic tick();
        item_t it;
        item_t dropped;
        bit    en;
        #1;
        en = out_ready || !mq[0].vld;
        chk("in_ready", 128'(in_ready), 128'(en));
        if (en) begin
            it = pick();
            mq.push_back(it);
            dropped = mq.pop_front();
            if (rr_mode && it.vld) m_ptr = int'(it.sel);
        end
        @(posedge clk);
        #1;
        chk("out_valid", 128'(out_valid), 128'(mq[0].vld));
        chk("out_sel", 128'(out_sel), 128'(mq[0].sel));
        if (mq[0].vld) chk("out_dat", 128'(out_dat), 128'(mq[0].dat));
    endtask

    function automatic void chk_sw(string nm, int c, int lat, int n, logic vld, int osel,
                                   logic [15:0] odat, int base);
        int k;
        bit ev;
        k  = c - lat + 1;
        ev = (k >= 0 && k < n);
        chk({nm, "_vld"}, 128'(vld), 128'(ev));
        if (ev) begin
            chk({nm, "_sel"}, 128'(osel), 128'(k));
            chk({nm, "_dat"}, 128'(odat), 128'(base + k));
        end
    endfunction

    typedef struct {
        logic [SW-1:0] sel;
        logic [N-1:0]  iv;
        logic [DW-1:0] lane0;
        logic [DW-1:0] e_dat;
        logic [SW-1:0] e_sel;
        logic          e_vld;
    } vec_t;

    vec_t  tbl [12];
    item_t hold;
    logic  rr_vld_exp [9];
    int    rr_sel_exp [9];
    logic [N-1:0] rr_iv [11];

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        tbl[0]  = '{3'd0, 5'b11111, 96'hA0, 96'hA0, 3'd0, 1'b1};
        tbl[1]  = '{3'd1, 5'b11111, 96'hA0, 96'hA1, 3'd1, 1'b1};
        tbl[2]  = '{3'd2, 5'b11111, 96'hA0, 96'hA2, 3'd2, 1'b1};
        tbl[3]  = '{3'd3, 5'b11111, 96'hA0, 96'hA3, 3'd3, 1'b1};
        tbl[4]  = '{3'd4, 5'b11111, 96'hA0, 96'hA4, 3'd4, 1'b1};
        tbl[5]  = '{3'd6, 5'b00001, 96'h55, 96'h55, 3'd0, 1'b1};
        tbl[6]  = '{3'd6, 5'b00000, 96'h55, 96'h0,  3'd0, 1'b0};
        tbl[7]  = '{3'd7, 5'b00001, 96'h66, 96'h66, 3'd0, 1'b1};
        tbl[8]  = '{3'd5, 5'b11111, 96'h77, 96'h77, 3'd0, 1'b1};
        tbl[9]  = '{3'd3, 5'b10111, 96'hA0, 96'h0,  3'd3, 1'b0};
        tbl[10] = '{3'd4, 5'b10000, 96'hA0, 96'hA4, 3'd4, 1'b1};
        tbl[11] = '{3'd2, 5'b00100, 96'hA0, 96'hA2, 3'd2, 1'b1};

        rr_iv = '{5'b10110, 5'b10110, 5'b10110, 5'b10110, 5'b10110, 5'b10110,
                  5'b00000, 5'b00000, 5'b11111, 5'b00000, 5'b00000};
        rr_vld_exp = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1};
        rr_sel_exp = '{1, 2, 4, 1, 2, 4, 4, 4, 0};

        rst = 1'b0; sel = '0; rr_mode = 1'b0; in_valid = '0; out_ready = 1'b1;
        for (int i = 0; i < N; i++) lanes[i] = DW'(8'hA0 + i);
        sel16 = '0; iv16 = '0; sel17 = '0; iv17 = '0; sel2 = '0; iv2 = '0;

        #2;
        chk("rst_out", 128'(out_dat), 128'(0));
        chk("rst_out_valid", 128'(out_valid), 128'(0));
        chk("rst_out_sel", 128'(out_sel), 128'(0));
        chk("rst_sweep_vld", 128'({ov16, ov17, ov2}), 128'(0));
        @(posedge clk);
        #1;
        rst = 1'b1;
        model_reset();

        // Parameter sweep: walk sel over every lane of each configuration
        for (int c = 0; c < 22; c++) begin
            sel16 = 4'(c); iv16 = (c < 16) ? '1 : '0;
            sel17 = 5'(c); iv17 = (c < 17) ? '1 : '0;
            sel2  = 1'(c); iv2  = (c < 2)  ? '1 : '0;
            tick();
            chk_sw("sweep16", c, 2, 16, ov16, int'(os16), o16, 256);
            chk_sw("sweep17", c, 3, 17, ov17, int'(os17), o17, 512);
            chk_sw("sweep2",  c, 1, 2,  ov2,  int'(os2),  o2,  768);
        end
        chk("sweep_ready", 128'({ir16, ir17, ir2}), 128'(3'b111));

        // Table-driven fixed-mode vectors
        for (int i = 0; i <= 12; i++) begin
            if (i < 12) begin
                sel = tbl[i].sel;
                in_valid = tbl[i].iv;
                lanes[0] = tbl[i].lane0;
            end else begin
                in_valid = '0;
            end
            tick();
            if (i >= 1) begin
                chk("tbl_vld", 128'(out_valid), 128'(tbl[i-1].e_vld));
                chk("tbl_sel", 128'(out_sel), 128'(tbl[i-1].e_sel));
                if (tbl[i-1].e_vld) chk("tbl_dat", 128'(out_dat), 128'(tbl[i-1].e_dat));
            end
        end
        lanes[0] = DW'(8'hA0);

        // Round-robin grant order, idle hold, then restart from pointer 4
        rr_mode = 1'b1;
        for (int i = 0; i < 11; i++) begin
            in_valid = rr_iv[i];
            if (i >= 9) rr_mode = 1'b0;
            tick();
            if (i >= 1 && i <= 9) begin
                chk("rr_vld", 128'(out_valid), 128'(rr_vld_exp[i-1]));
                chk("rr_sel", 128'(out_sel), 128'(rr_sel_exp[i-1]));
                if (rr_vld_exp[i-1]) chk("rr_dat", 128'(out_dat), 128'(8'hA0 + rr_sel_exp[i-1]));
            end
        end

        // Backpressure: stall 3 cycles with valid output, then release
        rr_mode = 1'b1; in_valid = 5'b11111; out_ready = 1'b1;
        for (int i = 0; i < 3; i++) tick();
        out_ready = 1'b0;
        hold = mq[0];
        for (int i = 0; i < 3; i++) begin
            for (int j = 0; j < N; j++) lanes[j] = {$urandom, $urandom, $urandom};
            tick();
            chk("bp_hold_dat", 128'(out_dat), 128'(hold.dat));
            chk("bp_hold_sel", 128'(out_sel), 128'(hold.sel));
            chk("bp_in_ready", 128'(in_ready), 128'(0));
        end
        out_ready = 1'b1;
        for (int i = 0; i < 6; i++) tick();

        // Random traffic against the model
        for (int i = 0; i < 400; i++) begin
            if ($urandom_range(0, 15) == 0) rr_mode = ~rr_mode;
            sel = SW'($urandom_range(0, 7));
            in_valid = N'($urandom);
            for (int j = 0; j < N; j++) lanes[j] = {$urandom, $urandom, $urandom};
            out_ready = ($urandom_range(0, 3) != 0);
            tick();
        end

        // Asynchronous reset mid-stream
        rr_mode = 1'b0; sel = 3'd1; in_valid = 5'b11111; out_ready = 1'b1;
        for (int i = 0; i < 3; i++) tick();
        chk("pre_rst_valid", 128'(out_valid), 128'(1));
        #3;
        rst = 1'b0;
        #1;
        chk("arst_out", 128'(out_dat), 128'(0));
        chk("arst_out_valid", 128'(out_valid), 128'(0));
        chk("arst_out_sel", 128'(out_sel), 128'(0));
        model_reset();
        rr_mode = 1'b1; in_valid = 5'b11111;
        #2;
        rst = 1'b1;
        tick();
        tick();
        chk("post_rst_grant_vld", 128'(out_valid), 128'(1));
        chk("post_rst_grant_sel", 128'(out_sel), 128'(0));
        tick();
        chk("post_rst_grant2_sel", 128'(out_sel), 128'(1));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
